// File: rtl/fifo_ctrl_pkg.sv
// Shared types and default sizing for the FIFO sequencing front-end.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } ctrl_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/fifo_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered tie-break pointer.
module rr_arb2
  import fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Index of the requester that wins a tie; 0 after reset.
  logic ptr;

  // Grant a lone requester outright, break a tie with the pointer.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Move priority away from whoever was just granted; hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (gnt != 2'b00) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Push/pop sequencer for an external FIFO: arbitrates two producers, serves
// one consumer, tracks occupancy, drains on flush and cross-checks the
// FIFO's own full/empty flags.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_push,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        ack_push,
  input  logic              req_pop,
  output logic              ack_pop,
  input  logic              flush,
  output logic              flush_done,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              push,
  output logic              pop,
  output logic [DATA_W-1:0] pushedValue,
  output logic [CNT_W-1:0]  count,
  output logic              err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  ctrl_state_t       state;
  ctrl_state_t       state_next;
  logic [1:0]        req_elig;
  logic [1:0]        gnt;
  logic              push_en;
  logic              push_issue;
  logic              pop_issue;
  logic              ack_pop_next;
  logic              flush_done_next;
  logic              flag_bad;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  count_d;
  logic [DATA_W-1:0] value_next;

  // Occupancy step clamped to 0..DEPTH; a simultaneous push and pop cancel.
  function automatic logic [CNT_W-1:0] count_step(input logic [CNT_W-1:0] c,
                                                  input logic inc,
                                                  input logic dec);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dec && (c != FULL_CNT)) begin
      r = c + CNT_W'(1);
    end else if (dec && !inc && (c != '0)) begin
      r = c - CNT_W'(1);
    end
    return r;
  endfunction

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_elig),
    .en    (push_en),
    .gnt   (gnt)
  );

  // Eligibility: a requester acked this cycle sits out one cycle so it can
  // drop its request or present new data. A flush sampled in RUN already
  // blocks pushes so the drain sees a stable target.
  always_comb begin
    req_elig     = req_push & ~ack_push;
    push_en      = (state == RUN) && !flush && (count != FULL_CNT);
    push_issue   = (gnt != 2'b00);
    pop_issue    = (count != '0) && ((state == DRAIN) || (req_pop && !ack_pop));
    ack_pop_next = pop_issue && req_pop && !ack_pop;
    value_next   = gnt[1] ? data1 : data0;
    count_next   = count_step(count, push_issue, pop_issue);
    flag_bad     = ((count_d == '0) != fifo_empty) || ((count_d == FULL_CNT) != fifo_full);
  end

  // Flush sequencing state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Flush sequencing: RUN -> DRAIN until empty -> DONE for one cycle -> RUN.
  always_comb begin
    state_next      = state;
    flush_done_next = 1'b0;
    case (state)
      RUN: begin
        if (flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (count == '0) begin
          state_next      = DONE;
          flush_done_next = 1'b1;
        end
      end
      DONE: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Output stage: every port is driven from a register one cycle after the
  // request was sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      push        <= 1'b0;
      pop         <= 1'b0;
      ack_push    <= 2'b00;
      ack_pop     <= 1'b0;
      flush_done  <= 1'b0;
      count       <= '0;
      count_d     <= '0;
      err         <= 1'b0;
      pushedValue <= '0;
    end else begin
      push       <= push_issue;
      pop        <= pop_issue;
      ack_push   <= gnt;
      ack_pop    <= ack_pop_next;
      flush_done <= flush_done_next;
      count      <= count_next;
      count_d    <= count;
      err        <= err || flag_bad;
      if (push_issue) begin
        pushedValue <= value_next;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a pushed-data scoreboard and a simple
// occupancy model of the FIFO that drives the full/empty flags.
module tb_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic [1:0]        req_push;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [1:0]        ack_push;
  logic              req_pop;
  logic              ack_pop;
  logic              flush;
  logic              flush_done;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] pushedValue;
  logic [CNT_W-1:0]  count;
  logic              err;

  int                n_cmp = 0;
  int                n_bad = 0;
  int                fifo_occ;
  logic              corrupt_empty;
  logic [DATA_W-1:0] exp_q[$];

  fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_push    (req_push),
    .data0       (data0),
    .data1       (data1),
    .ack_push    (ack_push),
    .req_pop     (req_pop),
    .ack_pop     (ack_pop),
    .flush       (flush),
    .flush_done  (flush_done),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .push        (push),
    .pop         (pop),
    .pushedValue (pushedValue),
    .count       (count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO occupancy model: absorbs the push/pop strobes on each edge.
  always @(posedge clk) begin
    if (reset) fifo_occ <= 0;
    else fifo_occ <= fifo_occ + (push ? 1 : 0) - (pop ? 1 : 0);
  end
  assign fifo_empty = (fifo_occ == 0) ^ corrupt_empty;
  assign fifo_full  = (fifo_occ == DEPTH);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Advance one clock, sample 1ns later, and retire any push against the scoreboard.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (push === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_push", 32'(pushedValue), 32'hFFFF_FFFF);
      else chk("push_data", 32'(pushedValue), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic expect_io(input string tag, input int e_push, input int e_ack,
                           input int e_pop, input int e_ackpop, input int e_cnt);
    chk({tag, ".push"},     32'(push),     e_push);
    chk({tag, ".ack_push"}, 32'(ack_push), e_ack);
    chk({tag, ".pop"},      32'(pop),      e_pop);
    chk({tag, ".ack_pop"},  32'(ack_pop),  e_ackpop);
    chk({tag, ".count"},    32'(count),    e_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_push = 2'b00; req_pop = 1'b0; flush = 1'b0;
    data0 = '0; data1 = '0; corrupt_empty = 1'b0;

    // Reset state
    do_reset();
    expect_io("rst", 0, 0, 0, 0, 0);
    chk("rst.value", 32'(pushedValue), 0);
    chk("rst.flush_done", 32'(flush_done), 0);
    chk("rst.err", 32'(err), 0);

    // Single push from producer 0
    req_push = 2'b01; data0 = 8'hA5; exp_q.push_back(8'hA5);
    cyc();
    expect_io("p0", 1, 1, 0, 0, 1);
    req_push = 2'b00;
    cyc();
    expect_io("p0_idle", 0, 0, 0, 0, 1);
    req_pop = 1'b1;
    cyc();
    expect_io("p0_pop", 0, 0, 1, 1, 0);
    req_pop = 1'b0;
    cyc();
    expect_io("p0_pop_idle", 0, 0, 0, 0, 0);

    // Both producers, fill from empty: strict alternation, stop at DEPTH
    do_reset();
    data0 = 8'h11; data1 = 8'h22; req_push = 2'b11;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back((i % 2 == 0) ? 8'h11 : 8'h22);
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      expect_io("fill", 1, (i % 2 == 0) ? 1 : 2, 0, 0, i + 1);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      expect_io("full_hold", 0, 0, 0, 0, DEPTH);
    end
    chk("full.err", 32'(err), 0);

    // Full with pop and push both requested: pop first, push refills
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    req_pop = 1'b1;
    cyc(); expect_io("full_c1", 0, 0, 1, 1, DEPTH - 1);
    cyc(); expect_io("full_c2", 1, 1, 0, 0, DEPTH);
    cyc(); expect_io("full_c3", 0, 0, 1, 1, DEPTH - 1);
    cyc(); expect_io("full_c4", 1, 2, 0, 0, DEPTH);
    req_pop = 1'b0; req_push = 2'b00;
    cyc(); expect_io("full_end", 0, 0, 0, 0, DEPTH);
    chk("full_end.err", 32'(err), 0);

    // Empty: pop request waits, a push then lets it through
    do_reset();
    req_pop = 1'b1;
    cyc(); expect_io("empty_a", 0, 0, 0, 0, 0);
    cyc(); expect_io("empty_b", 0, 0, 0, 0, 0);
    req_push = 2'b10; data1 = 8'h3C; exp_q.push_back(8'h3C);
    cyc(); expect_io("empty_push", 1, 2, 0, 0, 1);
    req_push = 2'b00;
    cyc(); expect_io("empty_pop", 0, 0, 1, 1, 0);
    cyc(); expect_io("empty_after", 0, 0, 0, 0, 0);
    req_pop = 1'b0;

    // Fill to 5 then flush with both producers still requesting
    data0 = 8'h44; data1 = 8'h55; req_push = 2'b11;
    exp_q.push_back(8'h44); exp_q.push_back(8'h55); exp_q.push_back(8'h44);
    exp_q.push_back(8'h55); exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    for (int i = 0; i < 5; i++) begin
      cyc();
      expect_io("pre_flush", 1, (i % 2 == 0) ? 1 : 2, 0, 0, i + 1);
    end
    flush = 1'b1;
    cyc(); expect_io("flush_enter", 0, 0, 0, 0, 5);
    flush = 1'b0;
    for (int j = 0; j < 5; j++) begin
      flush = (j == 1);
      cyc();
      expect_io("drain", 0, 0, 1, 0, 4 - j);
      chk("drain.flush_done", 32'(flush_done), 0);
    end
    flush = 1'b0;
    cyc(); expect_io("done", 0, 0, 0, 0, 0);
    chk("done.flush_done", 32'(flush_done), 1);
    cyc(); expect_io("done_after", 0, 0, 0, 0, 0);
    chk("done_after.flush_done", 32'(flush_done), 0);
    cyc(); expect_io("resume", 1, 2, 0, 0, 1);
    req_push = 2'b00;
    chk("resume.err", 32'(err), 0);

    // Flag mismatch sets a sticky error
    do_reset();
    corrupt_empty = 1'b1;
    cyc(); chk("err_set", 32'(err), 1);
    corrupt_empty = 1'b0;
    cyc(); chk("err_sticky1", 32'(err), 1);
    cyc(); chk("err_sticky2", 32'(err), 1);

    // Reset while draining returns everything to reset values
    data0 = 8'h77; data1 = 8'h78; req_push = 2'b11;
    exp_q.push_back(8'h77); exp_q.push_back(8'h78);
    cyc(); expect_io("pre_drain1", 1, 1, 0, 0, 1);
    cyc(); expect_io("pre_drain2", 1, 2, 0, 0, 2);
    req_push = 2'b00; flush = 1'b1;
    cyc(); expect_io("in_drain", 0, 0, 0, 0, 2);
    chk("in_drain.err", 32'(err), 1);
    flush = 1'b0; reset = 1'b1; req_push = 2'b11; req_pop = 1'b1;
    cyc();
    expect_io("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst.value", 32'(pushedValue), 0);
    chk("mid_rst.flush_done", 32'(flush_done), 0);
    chk("mid_rst.err", 32'(err), 0);
    reset = 1'b0; req_pop = 1'b0; exp_q.push_back(8'h77);
    cyc(); expect_io("post_rst", 1, 1, 0, 0, 1);
    req_push = 2'b00;
    cyc(); expect_io("post_rst_idle", 0, 0, 0, 0, 1);
    chk("post_rst.err", 32'(err), 0);

    chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
